sd_dat_card_emu: RTL and testbench
==================================

// Module: sd_dat_card_emu
// PURPOSE
//  Synthesizable SD-card-side DAT-line emulator. Successor to the fixed 4-bit DAT stimulus.
//  Read mode: drives start bit, patterned data, per-lane CRC16 and end bit for N blocks.
//  Write mode: receives host blocks, checks per-lane CRC16, returns CRC-status token plus busy.
//  Sits opposite DAT_control/DAT_phys in benches and FPGA loopback, clocked by the card clock.
// PARAMETERS
//  DAT_W            4   bus width; legal values 1, 4, 8
//  BLOCK_SZ_WIDTH  12   width of block_sz (bytes per block)
//  BLOCK_CNT_WIDTH 16   width of block_cnt
//  NAC_CYCLES       8   idle cycles between start_rd/end of a block and the next start bit
//  BUSY_CYCLES      4   cycles DAT[0] is held low after each write status token
//  WR_TIMEOUT     256   cycles to wait for a host start bit before abandoning a write
// PORTS
//  sd_clk       in   1                card clock; all logic on rising edge
//  rst          in   1                synchronous, active-high reset
//  start_rd     in   1                1-cycle pulse: begin read transfer (card -> host)
//  start_wr     in   1                1-cycle pulse: begin write transfer (host -> card)
//  abort        in   1                terminate current transfer
//  block_sz     in   BLOCK_SZ_WIDTH   bytes per block, sampled on start
//  block_cnt    in   BLOCK_CNT_WIDTH  blocks per transfer, sampled on start
//  pat_seed     in   8                data pattern seed, sampled on start
//  DAT_din      in   DAT_W            DAT lines as driven by host
//  DAT_dout     out  DAT_W            DAT lines driven by card
//  DAT_oe       out  1                card output enable
//  busy         out  1                transfer in progress
//  blk_done     out  1                1-cycle pulse per completed block
//  done         out  1                1-cycle pulse at end of transfer (not on abort)
//  crc_err_cnt  out  BLOCK_CNT_WIDTH  write blocks failing CRC or end bit, cleared on start
// BEHAVIOUR
//  Reset: DAT_dout all 1, DAT_oe 0, busy 0, blk_done 0, done 0, crc_err_cnt 0, state IDLE.
//  FSM: IDLE, R_GAP, R_START, R_DATA, R_CRC, R_END, W_WAIT, W_DATA, W_CRC, W_END, W_STAT, W_BUSY.
//  Start: accepted only in IDLE; start_rd wins if both pulse together; starts while busy are ignored.
//   block_cnt==0 or block_sz==0: done pulses next cycle, no bus activity, busy stays 0.
//  Data pattern: byte k of block b = pat_seed + b + k (mod 256).
//   Byte order MSB first. DAT_W=1: 8 cycles/byte. DAT_W=4: high nibble then low. DAT_W=8: 1 cycle/byte.
//   Data phase length = block_sz*8/DAT_W cycles.
//  Read: start_rd -> R_GAP (NAC_CYCLES, oe 1, lines 1) -> R_START (1 cycle, all lanes 0)
//   -> R_DATA -> R_CRC (16 cycles, per-lane CRC16 MSB first) -> R_END (all lanes 1).
//   After R_END, blk_done pulses; go to R_GAP if blocks remain, else oe 0, done, IDLE.
//  CRC16: poly x^16+x^12+x^5+1, init 0, one independent register per lane, data bits only.
//  Write: W_WAIT (oe 0) until DAT_din[0]==0. Timeout after WR_TIMEOUT cycles -> IDLE, no done.
//   Then W_DATA (same length as read) -> W_CRC (16 cycles, compare) -> W_END (expect all lanes 1).
//   CRC mismatch or bad end bit counts as error: crc_err_cnt increments, saturating.
//   W_STAT: 2 idle cycles, then on DAT[0] with oe 1: start bit 0, token, end bit 1.
//    Token is 3'b010 on good block, 3'b101 on error. Other lanes are held 1.
//   W_BUSY: DAT[0]=0 for BUSY_CYCLES, then oe 0; blk_done pulses.
//   Then W_WAIT for the next block, or done + IDLE when all blocks are received.
//  abort in any non-IDLE state: next cycle DAT_dout all 1, oe 0, busy 0, IDLE, no done/blk_done.
//  rst mid-transfer: identical to power-on reset values; partial block is discarded.
//  Simultaneous abort and start in IDLE: start ignored.
// STRUCTURE
//  defines.v: CRC16 poly, status tokens (`TOKEN_OK 3'b010, `TOKEN_ERR 3'b101),
//   FSM state encodings, DAT_W legality check.
//  Sub-module sd_crc16_lane: 1-bit serial CRC16 with clr, en, din, crc[15:0];
//   instantiated DAT_W times in a generate loop, shared by read and write paths.
// TESTING
//  1. DAT_W=4, read, block_sz=64, block_cnt=4, seed=0x01: 4 frames; each is 8 gap cycles, start 0,
//     128 nibbles starting 0,1,0,2, CRC match, end F; 4 blk_done pulses then 1 done.
//  2. DAT_W=1 and DAT_W=8, read, block_sz=512, cnt=1: 4096 and 512 data cycles;
//     DAT_W=1 CRC equals 16'h7FA1 for an all-0xFF block.
//  3. DAT_W=4, write 2 good blocks from host model: tokens 0-010-1 each, 4 busy cycles,
//     crc_err_cnt==0, done.
//  4. Write with one flipped bit in lane 2 of block 1: token 0-101-1, crc_err_cnt==1,
//     block 2 still accepted.
//  5. abort mid R_DATA, and rst mid W_DATA: next cycle oe 0, lines all 1, busy 0, no done;
//     a fresh start_rd then works normally.
//  6. block_cnt=0 -> done next cycle, no oe; start_rd+start_wr together -> read; no start bit -> timeout at 256.

Source files
------------

// File: rtl/sd_dat_card_emu_pkg.sv
// Shared constants, FSM encoding and helpers for the SD DAT card emulator.
// Latency: n/a; backpressure: n/a.
package sd_dat_card_emu_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [2:0]  TOKEN_OK   = 3'b010;
    localparam logic [2:0]  TOKEN_ERR  = 3'b101;
    localparam int          CNT_W      = 16;

    typedef enum logic [3:0] {
        IDLE, R_GAP, R_START, R_DATA, R_CRC, R_END,
        W_WAIT, W_DATA, W_CRC, W_END, W_STAT, W_BUSY
    } state_e;

    function automatic logic dat_w_legal(input int w);
        return (w == 1) || (w == 4) || (w == 8);
    endfunction

endpackage

// File: rtl/sd_crc16_lane.sv
// One-lane serial CRC16 (x^16+x^12+x^5+1, init 0), MSB-first input.
// Latency: crc reflects din one cycle after en; backpressure: none.
module sd_crc16_lane
    import sd_dat_card_emu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        fb    = din ^ crc_q[15];
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_dat_card_emu.sv
// SD card-side DAT emulator: patterned read frames with per-lane CRC16; write receive with CRC-status token and busy.
// Latency: bus activity starts the cycle after a start pulse; backpressure: none, host must keep pace with sd_clk.
module sd_dat_card_emu
    import sd_dat_card_emu_pkg::*;
#(
    parameter int DAT_W           = 4,
    parameter int BLOCK_SZ_WIDTH  = 12,
    parameter int BLOCK_CNT_WIDTH = 16,
    parameter int NAC_CYCLES      = 8,
    parameter int BUSY_CYCLES     = 4,
    parameter int WR_TIMEOUT      = 256
) (
    input  logic                       sd_clk,
    input  logic                       rst,
    input  logic                       start_rd,
    input  logic                       start_wr,
    input  logic                       abort,
    input  logic [BLOCK_SZ_WIDTH-1:0]  block_sz,
    input  logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
    input  logic [7:0]                 pat_seed,
    input  logic [DAT_W-1:0]           DAT_din,
    output logic [DAT_W-1:0]           DAT_dout,
    output logic                       DAT_oe,
    output logic                       busy,
    output logic                       blk_done,
    output logic                       done,
    output logic [BLOCK_CNT_WIDTH-1:0] crc_err_cnt
);

    localparam int CPB = 8 / DAT_W;

    if (!dat_w_legal(DAT_W)) begin : g_bad_dat_w
        $error("sd_dat_card_emu: DAT_W must be 1, 4 or 8");
    end

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [BLOCK_SZ_WIDTH-1:0]  sz_q, sz_d, byte_q, byte_d;
    logic [BLOCK_CNT_WIDTH-1:0] nblk_q, nblk_d, blk_q, blk_d, err_cnt_q, err_cnt_d;
    logic [7:0]                 seed_q, seed_d;
    logic [2:0]                 sub_q, sub_d;
    logic                       err_q, err_d, done_q, done_d, blk_done_q, blk_done_d;

    logic [7:0]       pat_byte, pat_shift;
    logic [DAT_W-1:0] pat_dat, crc_bits, crc_din;
    logic             crc_clr, crc_en, data_last, blk_last, end_bad;
    logic [15:0]      crc_lane [DAT_W];
    logic [4:0]       stat_frame;
    logic [2:0]       stat_idx;

    // Byte k of block b is seed + b + k; the current lane slice is taken MSB first.
    assign pat_byte  = seed_q + blk_q[7:0] + byte_q[7:0];
    assign pat_shift = pat_byte << (32'(sub_q) * DAT_W);
    assign pat_dat   = pat_shift[7 -: DAT_W];
    assign data_last = (byte_q == sz_q - BLOCK_SZ_WIDTH'(1)) && (sub_q == 3'(CPB - 1));
    assign blk_last  = (blk_q == nblk_q - BLOCK_CNT_WIDTH'(1));

    assign crc_clr = (state_q == R_START) || (state_q == W_WAIT);
    assign crc_en  = (state_q == R_DATA) || (state_q == W_DATA);
    assign crc_din = (state_q == W_DATA) ? DAT_din : pat_dat;
    assign end_bad = err_q || (DAT_din != {DAT_W{1'b1}});

    for (genvar i = 0; i < DAT_W; i++) begin : g_lane
        sd_crc16_lane u_crc (
            .clk (sd_clk),
            .rst (rst),
            .clr (crc_clr),
            .en  (crc_en),
            .din (crc_din[i]),
            .crc (crc_lane[i])
        );
        assign crc_bits[i] = crc_lane[i][~cnt_q[3:0]];
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sz_q       <= '0;
            byte_q     <= '0;
            nblk_q     <= '0;
            blk_q      <= '0;
            err_cnt_q  <= '0;
            seed_q     <= '0;
            sub_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            blk_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sz_q       <= sz_d;
            byte_q     <= byte_d;
            nblk_q     <= nblk_d;
            blk_q      <= blk_d;
            err_cnt_q  <= err_cnt_d;
            seed_q     <= seed_d;
            sub_q      <= sub_d;
            err_q      <= err_d;
            done_q     <= done_d;
            blk_done_q <= blk_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sz_d       = sz_q;
        byte_d     = byte_q;
        nblk_d     = nblk_q;
        blk_d      = blk_q;
        err_cnt_d  = err_cnt_q;
        seed_d     = seed_q;
        sub_d      = sub_q;
        err_d      = err_q;
        done_d     = 1'b0;
        blk_done_d = 1'b0;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if ((start_rd || start_wr) && !abort) begin
                    sz_d      = block_sz;
                    nblk_d    = block_cnt;
                    seed_d    = pat_seed;
                    blk_d     = '0;
                    cnt_d     = '0;
                    err_cnt_d = '0;
                    if (block_cnt == '0 || block_sz == '0) done_d  = 1'b1;
                    else if (start_rd)                     state_d = R_GAP;
                    else                                   state_d = W_WAIT;
                end
                R_GAP: begin
                    if (cnt_q == CNT_W'(NAC_CYCLES - 1)) state_d = R_START;
                    else                                 cnt_d   = cnt_q + CNT_W'(1);
                end
                R_START: begin
                    state_d = R_DATA;
                    byte_d  = '0;
                    sub_d   = '0;
                end
                R_DATA, W_DATA: begin
                    if (data_last) begin
                        state_d = (state_q == R_DATA) ? R_CRC : W_CRC;
                        cnt_d   = '0;
                    end else if (sub_q == 3'(CPB - 1)) begin
                        sub_d  = '0;
                        byte_d = byte_q + BLOCK_SZ_WIDTH'(1);
                    end else begin
                        sub_d = sub_q + 3'd1;
                    end
                end
                R_CRC: begin
                    if (cnt_q == CNT_W'(15)) state_d = R_END;
                    else                     cnt_d   = cnt_q + CNT_W'(1);
                end
                R_END: begin
                    blk_done_d = 1'b1;
                    cnt_d      = '0;
                    if (blk_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = R_GAP;
                        blk_d   = blk_q + BLOCK_CNT_WIDTH'(1);
                    end
                end
                W_WAIT: begin
                    err_d = 1'b0;
                    if (!DAT_din[0]) begin
                        state_d = W_DATA;
                        byte_d  = '0;
                        sub_d   = '0;
                    end else if (cnt_q == CNT_W'(WR_TIMEOUT - 1)) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                W_CRC: begin
                    if (DAT_din != crc_bits) err_d = 1'b1;
                    if (cnt_q == CNT_W'(15)) state_d = W_END;
                    else                     cnt_d   = cnt_q + CNT_W'(1);
                end
                W_END: begin
                    err_d   = end_bad;
                    state_d = W_STAT;
                    cnt_d   = '0;
                    if (end_bad && err_cnt_q != '1) err_cnt_d = err_cnt_q + BLOCK_CNT_WIDTH'(1);
                end
                W_STAT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(6)) begin
                        state_d = W_BUSY;
                        cnt_d   = '0;
                    end
                end
                W_BUSY: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BUSY_CYCLES - 1)) begin
                        blk_done_d = 1'b1;
                        cnt_d      = '0;
                        if (blk_last) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = W_WAIT;
                            blk_d   = blk_q + BLOCK_CNT_WIDTH'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Status slot: two released cycles, then start 0, token MSB first, end 1 on DAT[0].
    assign stat_frame = {1'b0, (err_q ? TOKEN_ERR : TOKEN_OK), 1'b1};
    assign stat_idx   = 3'd6 - cnt_q[2:0];

    always_comb begin
        DAT_dout = '1;
        DAT_oe   = 1'b0;
        case (state_q)
            R_GAP, R_END: DAT_oe = 1'b1;
            R_START: begin
                DAT_oe   = 1'b1;
                DAT_dout = '0;
            end
            R_DATA: begin
                DAT_oe   = 1'b1;
                DAT_dout = pat_dat;
            end
            R_CRC: begin
                DAT_oe   = 1'b1;
                DAT_dout = crc_bits;
            end
            W_STAT: if (cnt_q >= CNT_W'(2)) begin
                DAT_oe      = 1'b1;
                DAT_dout[0] = stat_frame[stat_idx];
            end
            W_BUSY: begin
                DAT_oe      = 1'b1;
                DAT_dout[0] = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign blk_done    = blk_done_q;
    assign done        = done_q;
    assign crc_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_sd_dat_card_emu.sv
// Directed bench for sd_dat_card_emu at DAT_W 4, 1 and 8 with a host-side frame model.
module tb_sd_dat_card_emu;

    logic sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;

    logic        rst, start_rd, start_wr, abort;
    logic [11:0] block_sz;
    logic [15:0] block_cnt;
    logic [7:0]  pat_seed;
    logic [7:0]  hdin;
    int          sel = 4;

    logic [3:0]  dout4;
    logic [0:0]  dout1;
    logic [7:0]  dout8;
    logic        oe4, oe1, oe8, busy4, busy1, busy8, bd4, bd1, bd8, dn4, dn1, dn8;
    logic [15:0] ec4, ec1, ec8;

    logic [7:0]  o_dout;
    logic        o_oe, o_busy, o_bd, o_dn;
    logic [15:0] o_ec;

    int total = 0;
    int bad   = 0;

    sd_dat_card_emu #(.DAT_W(4)) u_dut4 (
        .sd_clk(sd_clk), .rst(rst), .start_rd(start_rd && sel == 4), .start_wr(start_wr && sel == 4),
        .abort(abort), .block_sz(block_sz), .block_cnt(block_cnt), .pat_seed(pat_seed),
        .DAT_din(hdin[3:0]), .DAT_dout(dout4), .DAT_oe(oe4), .busy(busy4),
        .blk_done(bd4), .done(dn4), .crc_err_cnt(ec4)
    );

    sd_dat_card_emu #(.DAT_W(1)) u_dut1 (
        .sd_clk(sd_clk), .rst(rst), .start_rd(start_rd && sel == 1), .start_wr(start_wr && sel == 1),
        .abort(abort), .block_sz(block_sz), .block_cnt(block_cnt), .pat_seed(pat_seed),
        .DAT_din(hdin[0:0]), .DAT_dout(dout1), .DAT_oe(oe1), .busy(busy1),
        .blk_done(bd1), .done(dn1), .crc_err_cnt(ec1)
    );

    sd_dat_card_emu #(.DAT_W(8)) u_dut8 (
        .sd_clk(sd_clk), .rst(rst), .start_rd(start_rd && sel == 8), .start_wr(start_wr && sel == 8),
        .abort(abort), .block_sz(block_sz), .block_cnt(block_cnt), .pat_seed(pat_seed),
        .DAT_din(hdin), .DAT_dout(dout8), .DAT_oe(oe8), .busy(busy8),
        .blk_done(bd8), .done(dn8), .crc_err_cnt(ec8)
    );

    always_comb begin
        case (sel)
            1: begin
                o_dout = {7'h7F, dout1}; o_oe = oe1; o_busy = busy1; o_bd = bd1; o_dn = dn1; o_ec = ec1;
            end
            8: begin
                o_dout = dout8; o_oe = oe8; o_busy = busy8; o_bd = bd8; o_dn = dn8; o_ec = ec8;
            end
            default: begin
                o_dout = {4'hF, dout4}; o_oe = oe4; o_busy = busy4; o_bd = bd4; o_dn = dn4; o_ec = ec4;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sd_clk);
        #1;
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        return {c[14:0], 1'b0} ^ ((d ^ c[15]) ? 16'h1021 : 16'h0000);
    endfunction

    // Lane bits of one bus cycle: byte shifted MSB first, lane i carries bit i of the slice.
    function automatic logic [7:0] slice(input int w, input logic [7:0] b, input int sub);
        logic [7:0] s;
        s = b << (sub * w);
        return s >> (8 - w);
    endfunction

    // Entered on the first gap cycle of a frame; leaves on the cycle after the end bit.
    task automatic rd_frame(input int w, input int b, input int sz, input int seed, input bit last,
                            output logic [15:0] first4);
        logic [15:0] crc [8];
        logic [7:0]  m, e, byte_v;
        int          nerr;
        m = 8'((1 << w) - 1);
        for (int i = 0; i < 8; i++) crc[i] = '0;
        nerr = 0;
        for (int g = 0; g < 8; g++) begin
            if (o_oe !== 1'b1 || (o_dout & m) !== m) nerr++;
            tick();
        end
        check("rd_gap", nerr, 0);
        check("rd_start", {o_oe, o_dout & m}, {1'b1, 8'h00});
        tick();
        nerr   = 0;
        first4 = '0;
        for (int c = 0; c < sz * 8 / w; c++) begin
            byte_v = 8'(seed + b + c / (8 / w));
            e = slice(w, byte_v, c % (8 / w));
            for (int i = 0; i < w; i++) crc[i] = crc_step(crc[i], e[i]);
            if (c < 4) first4 = {first4[11:0], o_dout[3:0]};
            if (o_oe !== 1'b1 || (o_dout & m) !== e) nerr++;
            tick();
        end
        check("rd_data", nerr, 0);
        nerr = 0;
        for (int k = 0; k < 16; k++) begin
            e = '0;
            for (int i = 0; i < w; i++) e[i] = crc[i][15 - k];
            if (o_oe !== 1'b1 || (o_dout & m) !== e) nerr++;
            tick();
        end
        check("rd_crc", nerr, 0);
        check("rd_end", {o_oe, o_dout & m}, {1'b1, m});
        tick();
        check("rd_blk_done", o_bd, 1);
        check("rd_done", o_dn, last);
        if (last) check("rd_idle", {o_busy, o_oe}, 0);
    endtask

    // Host sends one block (start, data, CRC, end) then checks the status token and busy.
    task automatic wr_block(input int w, input int b, input int sz, input int seed, input bit all_ff,
                            input bit force_7fa1, input bit flip, input bit exp_err, input bit last);
        logic [15:0] crc [8];
        logic [15:0] crc_ff;
        logic [7:0]  m, e, byte_v;
        logic [4:0]  stat;
        logic [6:0]  oes;
        int          nerr, nbusy;
        m      = 8'((1 << w) - 1);
        crc_ff = 16'h7FA1;
        for (int i = 0; i < 8; i++) crc[i] = '0;
        hdin = 8'hFF;
        tick();
        tick();
        check("wr_wait_oe", {o_busy, o_oe}, 2'b10);
        hdin = ~m;
        tick();
        for (int c = 0; c < sz * 8 / w; c++) begin
            byte_v = all_ff ? 8'hFF : 8'(seed + b + c / (8 / w));
            e = slice(w, byte_v, c % (8 / w));
            for (int i = 0; i < w; i++) crc[i] = crc_step(crc[i], e[i]);
            if (flip && c == 5) e[2] = ~e[2];
            hdin = ~m | e;
            tick();
        end
        for (int k = 0; k < 16; k++) begin
            e = '0;
            for (int i = 0; i < w; i++) e[i] = crc[i][15 - k];
            if (force_7fa1) e[0] = crc_ff[15 - k];
            hdin = ~m | e;
            tick();
        end
        hdin = 8'hFF;
        tick();
        nerr = 0;
        stat = '0;
        for (int j = 0; j < 7; j++) begin
            oes[6 - j] = o_oe;
            if (j >= 2) stat[6 - j] = o_dout[0];
            if ((o_dout & m & 8'hFE) !== (m & 8'hFE)) nerr++;
            tick();
        end
        nbusy = 0;
        for (int j = 0; j < 4; j++) begin
            if (o_oe === 1'b1 && o_dout[0] === 1'b0) nbusy++;
            if ((o_dout & m & 8'hFE) !== (m & 8'hFE)) nerr++;
            tick();
        end
        check("wr_stat_oe", oes, 7'b0011111);
        check("wr_token", stat, exp_err ? 5'b01011 : 5'b00101);
        check("wr_lanes_hi", nerr, 0);
        check("wr_busy", nbusy, 4);
        check("wr_release", {o_oe, o_bd, o_dn}, {1'b0, 1'b1, last});
    endtask

    task automatic pulse_start(input bit rd, input bit wr, input int s, input int sz, input int cnt, input int seed);
        sel       = s;
        block_sz  = 12'(sz);
        block_cnt = 16'(cnt);
        pat_seed  = 8'(seed);
        start_rd  = rd;
        start_wr  = wr;
        tick();
        start_rd  = 1'b0;
        start_wr  = 1'b0;
    endtask

    initial begin
        logic [15:0] f4;
        rst = 1'b1; start_rd = 1'b0; start_wr = 1'b0; abort = 1'b0;
        block_sz = '0; block_cnt = '0; pat_seed = '0; hdin = 8'hFF;
        tick(); tick(); tick();
        check("rst_dout", o_dout, 8'hFF);
        check("rst_ctrl", {o_oe, o_busy, o_bd, o_dn}, 4'b0000);
        check("rst_err_cnt", o_ec, 0);
        check("rst_other_widths", {oe1, oe8, busy1, busy8, dout1, dout8}, {4'b0000, 1'b1, 8'hFF});
        rst = 1'b0;
        tick();

        // Four 64-byte blocks at 4 lanes, seed 0x01.
        pulse_start(1, 0, 4, 64, 4, 8'h01);
        for (int b = 0; b < 4; b++) begin
            rd_frame(4, b, 64, 8'h01, b == 3, f4);
            if (b == 0) check("t1_first_nibbles_b0", f4, 16'h0102);
            if (b == 1) check("t1_first_nibbles_b1", f4, 16'h0203);
        end

        // 512-byte reads at 1 and 8 lanes, then a 1-lane all-0xFF write carrying CRC 7FA1.
        pulse_start(1, 0, 1, 512, 1, 8'h5A);
        rd_frame(1, 0, 512, 8'h5A, 1, f4);
        pulse_start(1, 0, 8, 512, 1, 8'hC3);
        rd_frame(8, 0, 512, 8'hC3, 1, f4);
        pulse_start(0, 1, 1, 512, 1, 0);
        wr_block(1, 0, 512, 0, 1, 1, 0, 0, 1);
        check("t2_w1_err_cnt", o_ec, 0);

        // Two good write blocks.
        pulse_start(0, 1, 4, 32, 2, 8'h10);
        wr_block(4, 0, 32, 8'h10, 0, 0, 0, 0, 0);
        wr_block(4, 1, 32, 8'h10, 0, 0, 0, 0, 1);
        check("t3_err_cnt", o_ec, 0);

        // Lane 2 corrupted in block 1; block 2 must still be accepted.
        pulse_start(0, 1, 4, 32, 2, 8'h77);
        wr_block(4, 0, 32, 8'h77, 0, 0, 1, 1, 0);
        check("t4_err_cnt_b1", o_ec, 1);
        wr_block(4, 1, 32, 8'h77, 0, 0, 0, 0, 1);
        check("t4_err_cnt_b2", o_ec, 1);

        // Abort in the middle of read data.
        pulse_start(1, 0, 4, 64, 2, 8'h20);
        repeat (8 + 1 + 20) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_bus", {o_oe, o_dout}, {1'b0, 8'hFF});
        check("t5_abort_ctrl", {o_busy, o_bd, o_dn}, 3'b000);
        repeat (5) tick();
        check("t5_abort_quiet", {o_busy, o_dn}, 2'b00);
        pulse_start(1, 0, 4, 8, 1, 8'h33);
        rd_frame(4, 0, 8, 8'h33, 1, f4);

        // Synchronous reset in the middle of write data.
        pulse_start(0, 1, 4, 32, 1, 8'h44);
        hdin = 8'hF0;
        tick();
        for (int c = 0; c < 10; c++) begin
            hdin = 8'(c);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hdin = 8'hFF;
        check("t5_rst_bus", {o_oe, o_dout}, {1'b0, 8'hFF});
        check("t5_rst_ctrl", {o_busy, o_bd, o_dn}, 3'b000);
        pulse_start(1, 0, 4, 8, 1, 8'h99);
        rd_frame(4, 0, 8, 8'h99, 1, f4);

        // Zero-length transfers finish at once without bus activity.
        pulse_start(1, 0, 4, 64, 0, 0);
        check("t6_cnt0_done", {o_dn, o_busy, o_oe}, 3'b100);
        tick();
        check("t6_cnt0_after", o_dn, 0);
        pulse_start(0, 1, 4, 0, 3, 0);
        check("t6_sz0_done", {o_dn, o_busy, o_oe}, 3'b100);

        // Both starts together select read.
        pulse_start(1, 1, 4, 8, 1, 8'h05);
        rd_frame(4, 0, 8, 8'h05, 1, f4);

        // Abort alongside a start in IDLE suppresses the start.
        abort = 1'b1;
        pulse_start(1, 0, 4, 8, 1, 0);
        abort = 1'b0;
        check("t6_abort_start", {o_busy, o_oe, o_dn}, 3'b000);

        // Write with no host start bit times out after 256 cycles.
        pulse_start(0, 1, 4, 8, 1, 0);
        hdin = 8'hFF;
        repeat (255) tick();
        check("t6_timeout_pending", o_busy, 1);
        tick();
        check("t6_timeout_idle", {o_busy, o_dn, o_bd}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
